bram_access_arbiter: RTL and testbench
======================================

// Module: bram_access_arbiter
// PURPOSE
//  Shares the single-port image BRAM between the SPI transfer path (com) and the
//  image-processing engine (pdi). Uses a per-requester req/gnt handshake, bounded
//  bursts for fairness, and read-data routing that stays correct across owner
//  switches. Replaces the static pdi_active mux in front of bram_controller.
// PARAMETERS
//  ADDR_W     17   BRAM address width
//  DATA_W     8    BRAM data width
//  MAX_BURST  256  max consecutive accepted accesses per owner while the other requests
//  RD_LAT     1    BRAM read latency in cycles (>=1)
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous, active-high reset
//  com_req     in   1       com requests an access this cycle
//  com_we      in   1       1=write, 0=read (valid with com_req)
//  com_addr    in   ADDR_W  com address
//  com_wdata   in   DATA_W  com write data
//  com_gnt     out  1       com owns BRAM; access accepted when com_req&com_gnt
//  com_rvalid  out  1       bram_rdata valid for com's read
//  pdi_req     in   1       pdi requests an access
//  pdi_we      in   1       pdi write enable
//  pdi_addr    in   ADDR_W  pdi address
//  pdi_wdata   in   DATA_W  pdi write data
//  pdi_gnt     out  1       pdi owns BRAM
//  pdi_rvalid  out  1       bram_rdata valid for pdi's read
//  bram_addr   out  ADDR_W  to BRAM
//  bram_we     out  1       to BRAM
//  bram_wdata  out  DATA_W  to BRAM
//  bram_rdata  in   DATA_W  from BRAM; forwarded unregistered to both requesters
//  owner       out  2       0=none, 1=com, 2=pdi (debug/LED)
// BEHAVIOUR
//  - Clocking/reset: one clock (clk); rst is synchronous and active-high.
//  - FSM states: IDLE, COM, PDI. Registered. com_gnt=(state==COM),
//    pdi_gnt=(state==PDI), owner encodes state.
//  - IDLE: com_req -> COM (com has priority, both-requesting included);
//    else pdi_req -> PDI; else stay.
//  - COM: stay while com_req. If com_req=0: go to PDI if pdi_req, else IDLE.
//    PDI is symmetric, with pdi and com swapped.
//  - Burst cap: burst_cnt counts accepted accesses of the current owner. If the
//    accepted access makes burst_cnt==MAX_BURST and the other requester's req=1,
//    the next state is the other owner and burst_cnt clears.
//    Otherwise burst_cnt saturates at MAX_BURST.
//  - burst_cnt clears on every state change.
//  - Grant lands the cycle after the state decision. A switch costs no bubble
//    beyond the owner's own req=0 cycle. A cap switch has zero bubble.
//  - Accept: acc = req & gnt of the owner. Combinational path:
//    bram_addr/wdata = owner's inputs.
//    In IDLE: bram_addr = 0, bram_wdata = 0.
//    bram_we = acc & owner_we. A non-owner never reaches BRAM.
//  - Read tag: an accepted read pushes a tag {valid, owner} into an RD_LAT-deep
//    shift register. com_rvalid/pdi_rvalid fire exactly RD_LAT cycles after
//    acceptance, for the tagged owner, even if ownership has since changed.
//  - Reset values: state=IDLE, burst_cnt=0, tag pipe cleared.
//    All gnt, rvalid and bram_we = 0. owner = 0.
//  - rst mid-burst: in-flight reads are dropped (no rvalid), and no BRAM write
//    occurs in the reset cycle.
//  - A requester sampling gnt=0 holds req and its address/data stable until
//    accepted. The arbiter never drops a held req.
// STRUCTURE
//  - Shared package bram_arb_pkg: owner encoding constants (OWN_NONE=0,
//    OWN_COM=1, OWN_PDI=2) and FSM state localparams.
//  - One sub-module: rd_tag_pipe (RD_LAT-deep {valid, owner} shift register,
//    synchronous clear).
//  - Top level holds the FSM, burst counter and the combinational port mux.
// TESTING
//  1. rst=1 for 2 cycles while both req=1 -> all gnt, rvalid, bram_we = 0 and
//     owner = 0 during reset; com_gnt=1 on the 1st cycle after release.
//  2. com read 0x00010 alone -> com_gnt next cycle; bram_addr=0x00010,
//     bram_we=0 on accept; com_rvalid exactly RD_LAT cycles later;
//     pdi_rvalid stays 0.
//  3. com_req and pdi_req rise in the same cycle from IDLE -> COM first. pdi
//     stalls with its address held; PDI is granted the cycle after com_req falls.
//  4. MAX_BURST=4, both req held continuously -> grant alternates every
//     4 accepted accesses (com 4, pdi 4, com 4...) with no idle cycle between.
//  5. com read accepted in its last burst cycle, switch to PDI -> the read's
//     rvalid goes to com_rvalid (not pdi_rvalid) RD_LAT cycles later.
//  6. pdi write burst, rst asserted on the 3rd access with a read in flight ->
//     bram_we=0 that cycle; no rvalid afterwards; state IDLE; burst_cnt=0.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the image BRAM arbiter.
// Owner encoding doubles as the FSM state encoding.
package bram_arb_pkg;

    typedef logic [1:0] own_t;

    localparam own_t OWN_NONE = 2'd0;
    localparam own_t OWN_COM  = 2'd1;
    localparam own_t OWN_PDI  = 2'd2;

    localparam own_t S_IDLE = OWN_NONE;
    localparam own_t S_COM  = OWN_COM;
    localparam own_t S_PDI  = OWN_PDI;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_COM  = S_COM,
        ST_PDI  = S_PDI
    } state_t;

    function automatic own_t state_owner(state_t s);
        return own_t'(s);
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Read tag delay line: carries {valid, owner} of each accepted read
// so read data is steered to whoever issued it, not the current owner.
module rd_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       push_valid,
    input  logic [1:0] push_owner,
    output logic       out_valid,
    output logic [1:0] out_owner
);

    logic [DEPTH-1:0]      vld;
    logic [DEPTH-1:0][1:0] own;

    // Shift one stage per cycle; clear drops every in-flight read
    always_ff @(posedge clk) begin
        if (clr) begin
            vld <= '0;
            own <= '0;
        end else begin
            vld[0] <= push_valid;
            own[0] <= push_owner;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                own[i] <= own[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_owner = own[DEPTH-1];

endmodule

// File: rtl/bram_access_arbiter.sv
// Arbiter sharing the single-port image BRAM between com and pdi:
// req/gnt handshake, bounded bursts, owner-tagged read valids.
module bram_access_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W    = 17,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 256,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              com_req,
    input  logic              com_we,
    input  logic [ADDR_W-1:0] com_addr,
    input  logic [DATA_W-1:0] com_wdata,
    output logic              com_gnt,
    output logic              com_rvalid,
    input  logic              pdi_req,
    input  logic              pdi_we,
    input  logic [ADDR_W-1:0] pdi_addr,
    input  logic [DATA_W-1:0] pdi_wdata,
    output logic              pdi_gnt,
    output logic              pdi_rvalid,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic [1:0]        owner
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             acc;
    logic             cap_hit;
    logic             owner_we;
    logic             tag_valid;
    logic [1:0]       tag_owner;

    // Read data is wired straight to both requesters outside this block
    logic unused_rdata;
    assign unused_rdata = ^bram_rdata;

    // Grants come from the registered state; masked while in reset
    assign com_gnt = (state == ST_COM) & ~rst;
    assign pdi_gnt = (state == ST_PDI) & ~rst;
    assign owner   = rst ? OWN_NONE : state_owner(state);

    assign acc = (com_gnt & com_req) | (pdi_gnt & pdi_req);

    assign cnt_inc = (burst_cnt >= CNT_MAX) ? burst_cnt
                                            : burst_cnt + 1'b1;
    assign cap_hit = acc & (cnt_inc == CNT_MAX);

    // Next owner: com wins from idle, release on req drop or cap hit
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (com_req)
                    state_nxt = ST_COM;
                else if (pdi_req)
                    state_nxt = ST_PDI;
            end
            ST_COM: begin
                if (!com_req)
                    state_nxt = pdi_req ? ST_PDI : ST_IDLE;
                else if (cap_hit && pdi_req)
                    state_nxt = ST_PDI;
            end
            ST_PDI: begin
                if (!pdi_req)
                    state_nxt = com_req ? ST_COM : ST_IDLE;
                else if (cap_hit && com_req)
                    state_nxt = ST_COM;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Burst length restarts on every ownership change
    always_comb begin
        burst_nxt = burst_cnt;
        if (state_nxt != state)
            burst_nxt = '0;
        else if (acc)
            burst_nxt = cnt_inc;
    end

    // State and burst counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Port mux: only the owner's inputs reach the BRAM
    always_comb begin
        bram_addr  = '0;
        bram_wdata = '0;
        owner_we   = 1'b0;
        unique case (state)
            ST_COM: begin
                bram_addr  = com_addr;
                bram_wdata = com_wdata;
                owner_we   = com_we;
            end
            ST_PDI: begin
                bram_addr  = pdi_addr;
                bram_wdata = pdi_wdata;
                owner_we   = pdi_we;
            end
            default: begin
                bram_addr  = '0;
                bram_wdata = '0;
                owner_we   = 1'b0;
            end
        endcase
    end

    assign bram_we = acc & owner_we;

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag (
        .clk        (clk),
        .clr        (rst),
        .push_valid (acc & ~owner_we),
        .push_owner (state_owner(state)),
        .out_valid  (tag_valid),
        .out_owner  (tag_owner)
    );

    assign com_rvalid = tag_valid & (tag_owner == OWN_COM) & ~rst;
    assign pdi_rvalid = tag_valid & (tag_owner == OWN_PDI) & ~rst;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Bench for bram_access_arbiter: directed scenarios then random traffic,
// all cycles compared against a transaction-level arbitration model.
module tb_bram_access_arbiter;

    localparam int AW  = 17;
    localparam int DW  = 8;
    localparam int MB  = 4;
    localparam int LAT = 2;
    localparam int STARVE_LIM = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          com_req = 1'b0, com_we = 1'b0;
    logic [AW-1:0] com_addr = '0;
    logic [DW-1:0] com_wdata = '0;
    logic          pdi_req = 1'b0, pdi_we = 1'b0;
    logic [AW-1:0] pdi_addr = '0;
    logic [DW-1:0] pdi_wdata = '0;
    logic [DW-1:0] bram_rdata = '0;
    logic          com_gnt, com_rvalid, pdi_gnt, pdi_rvalid;
    logic [AW-1:0] bram_addr;
    logic          bram_we;
    logic [DW-1:0] bram_wdata;
    logic [1:0]    owner;

    bram_access_arbiter #(
        .ADDR_W (AW), .DATA_W (DW), .MAX_BURST (MB), .RD_LAT (LAT)
    ) dut (
        .clk (clk), .rst (rst),
        .com_req (com_req), .com_we (com_we),
        .com_addr (com_addr), .com_wdata (com_wdata),
        .com_gnt (com_gnt), .com_rvalid (com_rvalid),
        .pdi_req (pdi_req), .pdi_we (pdi_we),
        .pdi_addr (pdi_addr), .pdi_wdata (pdi_wdata),
        .pdi_gnt (pdi_gnt), .pdi_rvalid (pdi_rvalid),
        .bram_addr (bram_addr), .bram_we (bram_we),
        .bram_wdata (bram_wdata), .bram_rdata (bram_rdata),
        .owner (owner)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int who; } rd_t;

    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  m_own = 0;
    int  m_cnt = 0;
    rd_t pend[$];
    bit  last_com_acc, last_pdi_acc;
    logic s_com_gnt, s_pdi_gnt, s_com_rv, s_pdi_rv, s_we;
    logic [1:0] s_owner;
    logic [AW-1:0] s_addr;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h",
                   tag, cyc, obs, exp);
        end
    endtask

    // One clock: check mid-cycle against the model, then advance it
    task automatic cycle();
        bit e_acc, e_we, e_cv, e_pv;
        bit mine, other;
        int e_addr, e_wd, n;
        bram_rdata = DW'($urandom);
        #4;
        s_com_gnt = com_gnt; s_pdi_gnt = pdi_gnt;
        s_com_rv = com_rvalid; s_pdi_rv = pdi_rvalid;
        s_we = bram_we; s_owner = owner; s_addr = bram_addr;
        e_acc = !rst && ((m_own == 1 && com_req) ||
                         (m_own == 2 && pdi_req));
        e_we = e_acc && (m_own == 1 ? com_we : pdi_we);
        e_cv = 0; e_pv = 0;
        foreach (pend[i])
            if (pend[i].due == cyc) begin
                if (pend[i].who == 1) e_cv = 1;
                else e_pv = 1;
            end
        if (rst) begin e_cv = 0; e_pv = 0; end
        chk("com_gnt", 32'(com_gnt), 32'(!rst && m_own == 1));
        chk("pdi_gnt", 32'(pdi_gnt), 32'(!rst && m_own == 2));
        chk("owner", 32'(owner), rst ? 0 : m_own);
        chk("bram_we", 32'(bram_we), 32'(e_we));
        chk("com_rvalid", 32'(com_rvalid), 32'(e_cv));
        chk("pdi_rvalid", 32'(pdi_rvalid), 32'(e_pv));
        if (!rst) begin
            e_addr = m_own == 1 ? int'(com_addr) :
                     m_own == 2 ? int'(pdi_addr) : 0;
            e_wd   = m_own == 1 ? int'(com_wdata) :
                     m_own == 2 ? int'(pdi_wdata) : 0;
            chk("bram_addr", 32'(bram_addr), e_addr);
            chk("bram_wdata", 32'(bram_wdata), e_wd);
        end
        last_com_acc = e_acc && m_own == 1;
        last_pdi_acc = e_acc && m_own == 2;
        @(posedge clk);
        if (rst) begin
            pend.delete();
            m_own = 0;
            m_cnt = 0;
        end else begin
            if (e_acc && !e_we)
                pend.push_back('{due: cyc + LAT, who: m_own});
            if (m_own == 0) begin
                m_own = com_req ? 1 : (pdi_req ? 2 : 0);
                m_cnt = 0;
            end else begin
                mine  = m_own == 1 ? com_req : pdi_req;
                other = m_own == 1 ? pdi_req : com_req;
                if (!mine) begin
                    m_own = other ? 3 - m_own : 0;
                    m_cnt = 0;
                end else begin
                    n = m_cnt + 1;
                    m_cnt = n > MB ? MB : n;
                    if (m_cnt == MB && other) begin
                        m_own = 3 - m_own;
                        m_cnt = 0;
                    end
                end
            end
        end
        while (pend.size() > 0 && pend[0].due <= cyc)
            void'(pend.pop_front());
        cyc++;
        #1;
    endtask

    bit c_pend, p_pend;
    int c_wait, p_wait;

    initial begin
        // T1: reset with both requesting
        com_req = 1; pdi_req = 1; com_addr = 17'h00aa;
        pdi_addr = 17'h00bb;
        rst = 1;
        cycle();
        chk("t1_owner_rst", 32'(s_owner), 0);
        cycle();
        chk("t1_gnt_rst", 32'({s_com_gnt, s_pdi_gnt}), 0);
        rst = 0;
        cycle();
        cycle();
        chk("t1_com_first", 32'(s_com_gnt), 1);
        chk("t1_pdi_wait", 32'(s_pdi_gnt), 0);
        com_req = 0; pdi_req = 0;
        repeat (4) cycle();

        // T2: single com read
        com_req = 1; com_we = 0; com_addr = 17'h00010;
        cycle();
        cycle();
        chk("t2_gnt", 32'(s_com_gnt), 1);
        chk("t2_addr", 32'(s_addr), 32'h10);
        chk("t2_we", 32'(s_we), 0);
        com_req = 0;
        cycle();
        chk("t2_rv_early", 32'(s_com_rv), 0);
        cycle();
        chk("t2_com_rv", 32'(s_com_rv), 1);
        chk("t2_pdi_rv", 32'(s_pdi_rv), 0);
        repeat (3) cycle();

        // T3: simultaneous requests, pdi waits with address held
        com_req = 1; com_we = 1; com_addr = 17'h00100;
        com_wdata = 8'h5a;
        pdi_req = 1; pdi_we = 0; pdi_addr = 17'h00200;
        cycle();
        cycle();
        chk("t3_com_first", 32'(s_com_gnt), 1);
        cycle();
        com_req = 0;
        cycle();
        chk("t3_pdi_not_yet", 32'(s_pdi_gnt), 0);
        cycle();
        chk("t3_pdi_gnt", 32'(s_pdi_gnt), 1);
        chk("t3_pdi_addr", 32'(s_addr), 32'h200);
        pdi_req = 0;
        repeat (4) cycle();

        // T4/T5: both held, bursts alternate; last com read goes to com
        com_req = 1; com_we = 0; com_addr = 17'h01000;
        pdi_req = 1; pdi_we = 1; pdi_addr = 17'h02000;
        pdi_wdata = 8'hc3;
        cycle();
        for (int k = 0; k < 16; k++) begin
            cycle();
            chk("t4_owner", 32'(s_owner), ((k / MB) % 2 == 0) ? 1 : 2);
            if (k == 5) begin
                chk("t5_com_rv", 32'(s_com_rv), 1);
                chk("t5_pdi_rv", 32'(s_pdi_rv), 0);
            end
        end
        com_req = 0; pdi_req = 0;
        repeat (4) cycle();

        // T6: reset in the middle of a pdi burst with a read in flight
        pdi_req = 1; pdi_we = 0; pdi_addr = 17'h00300;
        cycle();
        cycle();
        pdi_we = 1; pdi_addr = 17'h00301;
        cycle();
        pdi_addr = 17'h00302;
        rst = 1;
        cycle();
        chk("t6_we_rst", 32'(s_we), 0);
        chk("t6_rv_rst", 32'(s_pdi_rv), 0);
        rst = 0; pdi_req = 0;
        cycle();
        chk("t6_idle", 32'(s_owner), 0);
        chk("t6_rv_drop", 32'({s_com_rv, s_pdi_rv}), 0);
        repeat (3) cycle();

        // Random traffic obeying the hold-until-accepted protocol
        c_pend = 0; p_pend = 0; c_wait = 0; p_wait = 0;
        for (int t = 0; t < 800; t++) begin
            if (!c_pend && $urandom_range(0, 99) < 55) begin
                c_pend = 1;
                com_we = 1'($urandom);
                com_addr = AW'($urandom);
                com_wdata = DW'($urandom);
            end
            if (!p_pend && $urandom_range(0, 99) < 70) begin
                p_pend = 1;
                pdi_we = 1'($urandom);
                pdi_addr = AW'($urandom);
                pdi_wdata = DW'($urandom);
            end
            com_req = c_pend;
            pdi_req = p_pend;
            rst = ($urandom_range(0, 199) == 0);
            cycle();
            if (last_com_acc) begin c_pend = 0; c_wait = 0; end
            else if (c_pend) c_wait++;
            if (last_pdi_acc) begin p_pend = 0; p_wait = 0; end
            else if (p_pend) p_wait++;
            if (c_pend) chk("com_starve", 32'(c_wait > STARVE_LIM), 0);
            if (p_pend) chk("pdi_starve", 32'(p_wait > STARVE_LIM), 0);
        end
        rst = 0; com_req = 0; pdi_req = 0;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
